// File: rtl/cdc_request_arbiter.sv
// cdc_request_arbiter: round-robin arbiter for asynchronous 4-phase request/ack channels sharing one resource.
// Build option CDC_ARB_TIMEOUT_EN adds a busy-cycle watchdog that aborts a stuck grant and raises timeout_err.
module cdc_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req_async,
    output logic [NUM_REQ-1:0] ack,
    output logic               start,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot,
    input  logic               done,
    output logic               timeout_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam int         CW      = IDX_W + 1;

    logic [NUM_REQ-1:0] sync1_r, sync2_r, sync2_d_r, pending_r, ack_r, onehot_r;
    logic [NUM_REQ-1:0] rise_s, pending_next_s, grant_mask_s, ack_set_s;
    logic [IDX_W-1:0]   ptr_r, gidx_r, pick_idx_s;
    logic [CW-1:0]      cand_s;
    logic [0:0]         state_r;
    logic               start_r, busy_r, pick_valid_s, grant_s, finish_s, timeout_hit_s;

    // Round-robin pick: scan downward in offset so the lowest offset after the pointer wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_s = {1'b0, ptr_r} + CW'(off);
            if (cand_s >= CW'(NUM_REQ)) cand_s = cand_s - CW'(NUM_REQ);
            else                        cand_s = cand_s;
            if (pending_r[cand_s[IDX_W-1:0]]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Grant/finish decisions and next pending/ack masks.
    always_comb begin
        grant_s      = (state_r == ST_IDLE) && enable && pick_valid_s;
        finish_s     = (state_r == ST_BUSY) && (done || timeout_hit_s);
        grant_mask_s = '0;
        if (grant_s) grant_mask_s[pick_idx_s] = 1'b1;
        else         grant_mask_s = '0;
        if (finish_s) ack_set_s = onehot_r;
        else          ack_set_s = '0;
        rise_s = sync2_r & ~sync2_d_r;
        // A pending request is dropped when withdrawn (sync2 low) or when granted.
        pending_next_s = (pending_r | (rise_s & ~ack_r)) & sync2_r & ~grant_mask_s;
    end

    // Synchronizers, pending flags, acks and the grant FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= '0;
            sync2_r   <= '0;
            sync2_d_r <= '0;
            pending_r <= '0;
            ack_r     <= '0;
            onehot_r  <= '0;
            gidx_r    <= '0;
            ptr_r     <= IDX_W'(NUM_REQ - 1);
            state_r   <= ST_IDLE;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (enable) begin
                sync1_r   <= req_async;
                sync2_r   <= sync1_r;
                sync2_d_r <= sync2_r;
            end else begin
                sync1_r   <= sync1_r;
                sync2_r   <= sync2_r;
                sync2_d_r <= sync2_d_r;
            end
            pending_r <= pending_next_s;
            ack_r     <= (ack_r & sync2_r) | ack_set_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        gidx_r   <= pick_idx_s;
                        onehot_r <= grant_mask_s;
                        start_r  <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ST_BUSY;
                    end else begin
                        start_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    start_r <= 1'b0;
                    if (finish_s) begin
                        ptr_r    <= gidx_r;
                        onehot_r <= '0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_BUSY;
                    end
                end
                default: begin
                    start_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    onehot_r <= '0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;

    // Limit is hit on the TIMEOUT_CYCLES-th busy cycle; a coincident done wins.
    assign timeout_hit_s = (state_r == ST_BUSY) && !done && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Busy-cycle counter and sticky abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r     <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (grant_s)                    tmo_cnt_r <= '0;
            else if (state_r == ST_BUSY)    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            else                            tmo_cnt_r <= tmo_cnt_r;
            if (timeout_hit_s) timeout_err_r <= 1'b1;
            else               timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign ack          = ack_r;
    assign start        = start_r;
    assign busy         = busy_r;
    assign grant_idx    = gidx_r;
    assign grant_onehot = onehot_r;

endmodule

// File: doc/cdc_request_arbiter.md
Name: cdc_request_arbiter

Overview:
- Round-robin arbiter for NUM_REQ asynchronous 4-phase request/acknowledge channels that share one resource in the clk domain.
- Each request is synchronized by a two-flop barrier, then rising-edge detected into a pending flag.
- One pending channel at a time is granted to the shared resource. The ack level is returned once the resource signals done.
- Sits between foreign-domain requesters and a single local service unit (e.g. a config or memory port).

Parameters:
- NUM_REQ, 4, number of requester channels (2..16).
- IDX_W, $clog2(NUM_REQ), width of grant index.
- TIMEOUT_CYCLES, 1024, busy-cycle limit before forced abort. Used only when CDC_ARB_TIMEOUT_EN is defined.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset; all flops clear immediately on assertion.
- enable, input, 1, synchronizer/edge-flop enable and new-grant permit.
- req_async, input, NUM_REQ, level requests from foreign domains; asynchronous to clk.
- ack, output, NUM_REQ, level acknowledges returned to requesters; registered.
- start, output, 1, one-cycle pulse marking the start of a grant; registered.
- busy, output, 1, high while a grant is in service; registered.
- grant_idx, output, IDX_W, index of the current or last grant; registered.
- grant_onehot, output, NUM_REQ, one-hot of grant_idx while busy, else 0; registered.
- done, input, 1, service-complete strobe from the resource.
- timeout_err, output, 1, sticky abort flag; tied 0 without the macro.

Behaviour:
- Reset values: ack=0, start=0, busy=0, grant_idx=0, grant_onehot=0, timeout_err=0, pending=0, sync flops=0, rr pointer=NUM_REQ-1 (so channel 0 wins first).
- Synchronizer: sync1<=req_async, sync2<=sync1, sync2_d<=sync2; all update only when enable=1. rise[i]=sync2[i]&~sync2_d[i].
- Pending: set on rise[i]. Cleared when channel i is granted (FSM IDLE->BUSY). Also cleared if sync2[i]=0 while not granted (request withdrawn). A set and a withdraw cannot coincide.
- Latency: with enable=1, req_async high before edge k gives pending set after edge k+2, start high in the cycle after edge k+3.
- FSM IDLE:
  - If enable=1 and pending!=0, pick the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Register grant_idx and grant_onehot, clear that pending bit, set start=1, busy=1, go to BUSY.
  - done in IDLE is ignored.
- FSM BUSY:
  - start drops after one cycle.
  - done=1, including the cycle start=1, sets ack[grant_idx]=1, pointer<=grant_idx, busy=0, grant_onehot=0, and returns to IDLE.
  - No new grant is issued in the cycle that done is accepted; the earliest next start is 2 cycles after done.
- enable=0: synchronizers freeze and no new grants are issued. A BUSY grant still completes on done.
- Ack release: ack[i] clears the cycle after sync2[i]=0. A channel whose request dropped during BUSY gets ack set on done, then cleared on the following edge.
- Re-request: a rise on channel i cannot re-pend while ack[i]=1, because the 4-phase protocol requires the request to drop first.
- Fairness: after channel i is served, every other pending channel is served before i again.
- rst mid-BUSY: immediately returns to IDLE with all outputs at reset values; the in-flight service is abandoned.

Optional Feature:
- Macro: CDC_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without done, the FSM returns to IDLE, sets ack[grant_idx]=1 (frees the requester) and sets timeout_err=1.
  - timeout_err stays set until rst.
  - done in the same cycle as the limit counts as a normal completion.
- Undefined: no counter; BUSY waits indefinitely; timeout_err is constant 0.

Test Plan:
- Single request, NUM_REQ=4, enable=1: req_async[2]=1 -> start pulse 4 edges later with grant_idx=2, grant_onehot=4'b0100. Then done after 3 cycles -> ack[2]=1, busy=0. Drop req -> ack[2]=0 within 3 cycles.
- Contention: req_async=4'b1111 simultaneously -> grants in order 0,1,2,3; each completes with done; every ack is asserted exactly once.
- Round-robin wrap: serve 3, then raise req 0 and 3 together -> grant 0 before 3.
- done with start: done=1 in the start cycle -> ack set next edge; done while IDLE -> no effect.
- enable=0 with pending[1] set -> no start. Raise enable -> start for 1. A grant in BUSY with enable=0 completes on done.
- CDC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: grant without done -> after 8 BUSY cycles busy=0, ack set, timeout_err=1. Assert rst mid-BUSY -> all outputs 0 immediately.
